// File: rtl/regfile_arb_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package regfile_arb_pkg;

   localparam int unsigned DefaultAw         = 5;
   localparam int unsigned DefaultDw         = 32;
   localparam int unsigned REGFILE_LAST_ADDR = 31;

   typedef enum logic [0:0] {
      StClear,
      StRun
   } arb_state_e;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Writeback requester bundle plus register-file write port of the arbiter.
interface regfile_write_arbiter_if
   import regfile_arb_pkg::*;
#(
   parameter int unsigned NREQ = 3,
   parameter int unsigned AW   = DefaultAw,
   parameter int unsigned DW   = DefaultDw
);
   logic [NREQ-1:0]    req_valid;
   logic [NREQ*AW-1:0] req_addr;
   logic [NREQ*DW-1:0] req_data;
   logic [NREQ-1:0]    req_ready;
   logic               we3;
   logic [AW-1:0]      wa3;
   logic [DW-1:0]      wd3;
   logic               busy;
   logic [2:0]         grant_id;

   // Requester / observer side.
   modport master (
      output req_valid, req_addr, req_data,
      input  req_ready, we3, wa3, wd3, busy, grant_id
   );

   // Arbiter side.
   modport slave (
      input  req_valid, req_addr, req_data,
      output req_ready, we3, wa3, wd3, busy, grant_id
   );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first request at or above ptr, wrapping.
module rr_arbiter #(
   parameter int unsigned NREQ = 3,
   localparam int unsigned IW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   ptr,
   output logic [NREQ-1:0] grant,
   output logic [IW-1:0]   grant_idx,
   output logic            any_grant
);

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      any_grant = 1'b0;
      // Upper segment [ptr, NREQ) first, then the wrapped segment [0, ptr).
      for (int i = 0; i < NREQ; i++) begin
         if (!any_grant && req[i] && (i >= int'(ptr))) begin
            any_grant = 1'b1;
            grant[i]  = 1'b1;
            grant_idx = IW'(i);
         end
      end
      for (int i = 0; i < NREQ; i++) begin
         if (!any_grant && req[i] && (i < int'(ptr))) begin
            any_grant = 1'b1;
            grant[i]  = 1'b1;
            grant_idx = IW'(i);
         end
      end
   end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin sharing of the register-file write port among writeback requesters.
// Optional post-reset clear of x1..x31 when REGFILE_CLEAR_ON_RESET_EN is defined.
module regfile_write_arbiter
   import regfile_arb_pkg::*;
#(
   parameter int unsigned NREQ = 3,
   parameter int unsigned AW   = DefaultAw,
   parameter int unsigned DW   = DefaultDw
) (
   input logic                    clk,
   input logic                    rst_n,
   regfile_write_arbiter_if.slave bus
);

   localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [NREQ-1:0] grant;
   logic [IW-1:0]   grant_idx;
   logic            any_grant;
   logic            run;
   logic            accept;
   logic [AW-1:0]   sel_addr;
   logic [DW-1:0]   sel_data;

   logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
   logic            we3_q, we3_d;
   logic [AW-1:0]   wa3_q, wa3_d;
   logic [DW-1:0]   wd3_q, wd3_d;
   logic [2:0]      grant_id_q, grant_id_d;

   rr_arbiter #(
      .NREQ (NREQ)
   ) u_rr_arbiter (
      .req       (bus.req_valid),
      .ptr       (rr_ptr_q),
      .grant     (grant),
      .grant_idx (grant_idx),
      .any_grant (any_grant)
   );

`ifdef REGFILE_CLEAR_ON_RESET_EN
   arb_state_e  state_q, state_d;
   logic [4:0]  clr_addr_q, clr_addr_d;

   assign run      = (state_q == StRun);
   assign bus.busy = (state_q == StClear);

   always_comb begin
      state_d    = state_q;
      clr_addr_d = clr_addr_q;
      if (state_q == StClear) begin
         clr_addr_d = clr_addr_q + 5'd1;
         if (clr_addr_q == 5'(REGFILE_LAST_ADDR)) begin
            state_d = StRun;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StClear;
         clr_addr_q <= 5'd1;
      end else begin
         state_q    <= state_d;
         clr_addr_q <= clr_addr_d;
      end
   end
`else
   assign run      = 1'b1;
   assign bus.busy = 1'b0;
`endif

   assign accept        = run & any_grant;
   assign bus.req_ready = run ? grant : '0;

   // One-hot AND-OR mux of the granted requester's address and data.
   always_comb begin
      sel_addr = '0;
      sel_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant[i]) begin
            sel_addr = bus.req_addr[i*AW +: AW];
            sel_data = bus.req_data[i*DW +: DW];
         end
      end
   end

   always_comb begin
      rr_ptr_d   = rr_ptr_q;
      we3_d      = 1'b0;
      wa3_d      = wa3_q;
      wd3_d      = wd3_q;
      grant_id_d = grant_id_q;
`ifdef REGFILE_CLEAR_ON_RESET_EN
      if (state_q == StClear) begin
         we3_d = 1'b1;
         wa3_d = AW'(clr_addr_q);
         wd3_d = '0;
      end
`endif
      if (accept) begin
         rr_ptr_d   = (grant_idx == IW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
         grant_id_d = 3'(grant_idx);
         // Writes to x0 are consumed but never reach the register file.
         if (sel_addr != '0) begin
            we3_d = 1'b1;
            wa3_d = sel_addr;
            wd3_d = sel_data;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_q   <= '0;
         we3_q      <= 1'b0;
         wa3_q      <= '0;
         wd3_q      <= '0;
         grant_id_q <= '0;
      end else begin
         rr_ptr_q   <= rr_ptr_d;
         we3_q      <= we3_d;
         wa3_q      <= wa3_d;
         wd3_q      <= wd3_d;
         grant_id_q <= grant_id_d;
      end
   end

   assign bus.we3      = we3_q;
   assign bus.wa3      = wa3_q;
   assign bus.wd3      = wd3_q;
   assign bus.grant_id = grant_id_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomized scoreboard bench for regfile_write_arbiter (either REGFILE_CLEAR_ON_RESET_EN build).
module tb_regfile_write_arbiter;

   localparam int NREQ = 3;
   localparam int AW   = 5;
   localparam int DW   = 32;
`ifdef REGFILE_CLEAR_ON_RESET_EN
   localparam int RunFrom = 31;
   localparam bit ClrEn   = 1'b1;
`else
   localparam int RunFrom = 0;
   localparam bit ClrEn   = 1'b0;
`endif

   typedef struct {
      int            cyc;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wr_t;

   logic clk;
   logic rst_n;
   int   cycle;
   int   vectors;
   int   miscompares;
   wr_t  q[$];

   // Reference-model state: pending requests, pointer, last granted index.
   bit            v[NREQ];
   logic [AW-1:0] a[NREQ];
   logic [DW-1:0] d[NREQ];
   int            ptr;
   logic [2:0]    exp_gid;

   regfile_write_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

   regfile_write_arbiter #(
      .NREQ (NREQ),
      .AW   (AW),
      .DW   (DW)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cycle <= 0;
      else        cycle <= cycle + 1;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s @cycle %0d: got %h expected %h", name, cycle, act, exp);
      end
   endtask

   // Monitor: every presented write must match the oldest expected write for this cycle.
   always @(negedge clk) begin
      if (rst_n) begin
         while (q.size() > 0 && q[0].cyc < cycle) begin
            wr_t w;
            w = q.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL missed_write @cycle %0d: expected wa3=%0d wd3=%h in cycle %0d",
                     cycle, w.addr, w.data, w.cyc);
         end
         if (bus.we3) begin
            if (q.size() == 0 || q[0].cyc != cycle) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_write @cycle %0d: got wa3=%0d wd3=%h, none expected",
                        cycle, bus.wa3, bus.wd3);
            end else begin
               wr_t w;
               w = q.pop_front();
               check("wa3", 64'(bus.wa3), 64'(w.addr));
               check("wd3", 64'(bus.wd3), 64'(w.data));
            end
         end
      end
   end

   // Model evaluation at the sampling edge: expected ready, then consume the grant.
   task automatic eval();
      logic [NREQ-1:0] exp_ready;
      int  sel;
      bit  busy_exp;
      busy_exp = (cycle < RunFrom);
      check("grant_id", 64'(bus.grant_id), 64'(exp_gid));
      check("busy", 64'(bus.busy), 64'(busy_exp));
      exp_ready = '0;
      sel       = -1;
      if (!busy_exp) begin
         for (int off = 0; off < NREQ; off++) begin
            int idx;
            idx = (ptr + off) % NREQ;
            if (sel < 0 && v[idx]) sel = idx;
         end
      end
      if (sel >= 0) exp_ready[sel] = 1'b1;
      check("req_ready", 64'(bus.req_ready), 64'(exp_ready));
      if (sel >= 0) begin
         exp_gid = 3'(sel);
         ptr     = (sel + 1) % NREQ;
         if (a[sel] != '0) q.push_back('{cyc: cycle + 1, addr: a[sel], data: d[sel]});
         v[sel] = 1'b0;
      end
   endtask

   // Called just after a rising edge: drive, evaluate at the falling edge, return after next rise.
   task automatic step();
      for (int i = 0; i < NREQ; i++) begin
         bus.req_valid[i]          = v[i];
         bus.req_addr[i*AW +: AW] = a[i];
         bus.req_data[i*DW +: DW] = d[i];
      end
      @(negedge clk);
      eval();
      @(posedge clk);
      #1;
   endtask

   task automatic release_reset();
      rst_n = 1'b1;
      if (ClrEn) begin
         for (int k = 1; k <= 31; k++) q.push_back('{cyc: k, addr: AW'(k), data: '0});
      end
   endtask

   task automatic random_traffic(input int n);
      for (int s = 0; s < n; s++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!v[i] && $urandom_range(0, 1) == 1) begin
               v[i] = 1'b1;
               a[i] = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom_range(0, 31));
               d[i] = $urandom;
            end
         end
         step();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vectors     = 0;
      miscompares = 0;
      ptr         = 0;
      exp_gid     = '0;
      rst_n       = 1'b0;
      bus.req_valid = '0;
      bus.req_addr  = '0;
      bus.req_data  = '0;
      for (int i = 0; i < NREQ; i++) begin
         v[i] = 1'b1;
         a[i] = AW'(5 + i);
         d[i] = DW'(32'hA + i);
      end
      repeat (3) @(posedge clk);
      #1;
      check("rst_we3", 64'(bus.we3), 64'(0));
      check("rst_wa3", 64'(bus.wa3), 64'(0));
      check("rst_wd3", 64'(bus.wd3), 64'(0));
      check("rst_busy", 64'(bus.busy), 64'(ClrEn));
      release_reset();

      // Clear sequence (if built) with all requesters waiting, then rotation 0,1,2,...
      while (cycle < RunFrom) begin
         step();
         for (int i = 0; i < NREQ; i++) v[i] = 1'b1;
      end
      for (int s = 0; s < 12; s++) begin
         step();
         for (int i = 0; i < NREQ; i++) v[i] = 1'b1;
      end

      // Pointer hold and skip: req2 alone, then req0 and req1.
      for (int i = 0; i < NREQ; i++) v[i] = 1'b0;
      step();
      v[2] = 1'b1;
      a[2] = AW'(9);
      d[2] = 32'h2222_0000;
      for (int k = 0; k < 8 && v[2]; k++) step();
      check("req2_granted", 64'(v[2]), 64'(0));
      v[0] = 1'b1;
      a[0] = AW'(10);
      d[0] = 32'h0000_1111;
      v[1] = 1'b1;
      a[1] = AW'(11);
      d[1] = 32'h1111_0000;
      for (int k = 0; k < 8 && (v[0] || v[1]); k++) step();
      check("req01_granted", 64'({v[0], v[1]}), 64'(0));
      step();

      // Address-0 write, then req0+req2 compete to expose the advanced pointer.
      v[1] = 1'b1;
      a[1] = '0;
      d[1] = 32'hFFFF_FFFF;
      step();
      v[0] = 1'b1;
      a[0] = AW'(3);
      d[0] = 32'h3030_3030;
      v[2] = 1'b1;
      a[2] = AW'(4);
      d[2] = 32'h4040_4040;
      step();
      step();
      step();

      random_traffic(150);

      // Reset during traffic; pending requests stay held through it.
      for (int i = 0; i < NREQ; i++) begin
         if (!v[i]) begin
            v[i] = 1'b1;
            a[i] = AW'(20 + i);
            d[i] = $urandom;
         end
      end
      for (int i = 0; i < NREQ; i++) begin
         bus.req_valid[i]          = v[i];
         bus.req_addr[i*AW +: AW] = a[i];
         bus.req_data[i*DW +: DW] = d[i];
      end
      @(negedge clk);
      eval();
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_we3", 64'(bus.we3), 64'(0));
      check("arst_wa3", 64'(bus.wa3), 64'(0));
      check("arst_wd3", 64'(bus.wd3), 64'(0));
      check("arst_gid", 64'(bus.grant_id), 64'(0));
      check("arst_busy", 64'(bus.busy), 64'(ClrEn));
      q.delete();
      ptr     = 0;
      exp_gid = '0;
      repeat (2) @(posedge clk);
      #1;
      release_reset();
      while (cycle < RunFrom) step();
      for (int k = 0; k < 8; k++) step();

      random_traffic(150);

      // Drain: no new requests, let everything retire.
      for (int k = 0; k < 20 && (v[0] || v[1] || v[2]); k++) step();
      step();
      step();
      check("queue_drained", 64'(q.size()), 64'(0));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
